// File: rtl/vga_pkg.sv
// vga_pkg: pattern mode encodings, colour-bar table and 640x480@60 timing defaults
package vga_pkg;

   typedef enum logic [1:0] {MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_BOX} mode_e;

   // {R,G,B} channel on/off per bar, index 0 is the leftmost bar:
   // white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [7:0][2:0] BAR_TBL = {
      3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
   };

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int line_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable divider, h/v scan counters and raw sync/display-enable
module vga_timing_gen import vga_pkg::*; #(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic       o_pix_en,
   output logic       o_frame_start,
   output logic       o_frame_end,
   output logic       o_hs,
   output logic       o_vs,
   output logic       o_de,
   output logic [9:0] o_hc,
   output logic [9:0] o_vc
);

   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit the 10-bit scan counters");
   end

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    hc_q, hc_d, vc_q, vc_d;
   logic          h_end, v_end;

   assign o_pix_en = div_q == DW'(CLK_DIV - 1);
   assign h_end    = hc_q == 10'(H_TOTAL - 1);
   assign v_end    = vc_q == 10'(V_TOTAL - 1);

   // divider free-runs; scan counters step only on pix_en, vc only on hc wrap
   always_comb begin
      div_d = o_pix_en ? '0 : div_q + DW'(1);
      hc_d  = !o_pix_en ? hc_q : h_end ? '0 : hc_q + 10'd1;
      vc_d  = !(o_pix_en && h_end) ? vc_q : v_end ? '0 : vc_q + 10'd1;
   end

   // counter state, cleared asynchronously so a reset mid-frame restarts at (0,0)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q <= '0;
         hc_q  <= '0;
         vc_q  <= '0;
      end else begin
         div_q <= div_d;
         hc_q  <= hc_d;
         vc_q  <= vc_d;
      end
   end

   // compared one bit wider so a porch ending exactly at 1024 does not alias to 0
   assign o_hs = {1'b0, hc_q} >= 11'(H_ACTIVE + H_FP) && {1'b0, hc_q} < 11'(H_ACTIVE + H_FP + H_SYNC);
   assign o_vs = {1'b0, vc_q} >= 11'(V_ACTIVE + V_FP) && {1'b0, vc_q} < 11'(V_ACTIVE + V_FP + V_SYNC);
   assign o_de = {1'b0, hc_q} < 11'(H_ACTIVE) && {1'b0, vc_q} < 11'(V_ACTIVE);

   assign o_hc          = hc_q;
   assign o_vc          = vc_q;
   assign o_frame_start = o_pix_en && hc_q == '0 && vc_q == '0;
   assign o_frame_end   = o_pix_en && h_end && v_end;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA display engine producing solid, bars, checker and bouncing-box patterns
module vga_pattern_gen import vga_pkg::*; #(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int COLOR_W  = 4,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int CHK_LOG2 = 5,
   parameter int BOX_SIZE = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [1:0]           i_mode,
   input  logic [3*COLOR_W-1:0] i_fg,
   output logic [COLOR_W-1:0]   o_red,
   output logic [COLOR_W-1:0]   o_green,
   output logic [COLOR_W-1:0]   o_blue,
   output logic                 o_hs,
   output logic                 o_vs,
   output logic                 o_disp_en,
   output logic [9:0]           o_x,
   output logic [9:0]           o_y,
   output logic [15:0]          o_frame
);

   localparam int         CW     = 3 * COLOR_W;
   localparam logic [9:0] BX_MAX = 10'(H_ACTIVE - BOX_SIZE);
   localparam logic [9:0] BY_MAX = 10'(V_ACTIVE - BOX_SIZE);

   logic          pix_en, frame_start, frame_end, hs_raw, vs_raw, de_raw;
   logic [9:0]    hc, vc;
   mode_e         mode_q, mode_eff;
   logic [9:0]    bx_q, bx_d, by_q, by_d;
   logic          dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
   logic [2:0]    bar_idx, bar_on;
   logic [CW-1:0] bar_rgb, rgb_d, rgb_q;
   logic          chk_on, in_box;
   logic          hs_q, vs_q, de_q;
   logic [9:0]    x_q, y_q;
   logic [15:0]   frame_q;

   vga_timing_gen #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE),
      .H_FP    (H_FP),
      .H_SYNC  (H_SYNC),
      .H_BP    (H_BP),
      .V_ACTIVE(V_ACTIVE),
      .V_FP    (V_FP),
      .V_SYNC  (V_SYNC),
      .V_BP    (V_BP)
   ) u_timing (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .o_pix_en     (pix_en),
      .o_frame_start(frame_start),
      .o_frame_end  (frame_end),
      .o_hs         (hs_raw),
      .o_vs         (vs_raw),
      .o_de         (de_raw),
      .o_hc         (hc),
      .o_vc         (vc)
   );

   // colour of the pixel at (hc,vc); the frame's first pixel already uses the newly sampled mode
   always_comb begin
      mode_eff = frame_start ? mode_e'(i_mode) : mode_q;
      bar_idx  = '0;
      for (int k = 1; k < 8; k++) bar_idx = hc >= 10'(k * H_ACTIVE / 8) ? 3'(k) : bar_idx;
      bar_on  = BAR_TBL[bar_idx];
      bar_rgb = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}}, {COLOR_W{bar_on[0]}}};
      chk_on  = hc[CHK_LOG2] ^ vc[CHK_LOG2];
      in_box  = {1'b0, hc} >= {1'b0, bx_q} && {1'b0, hc} < {1'b0, bx_q} + 11'(BOX_SIZE) &&
                {1'b0, vc} >= {1'b0, by_q} && {1'b0, vc} < {1'b0, by_q} + 11'(BOX_SIZE);
      rgb_d   = !de_raw                 ? '0 :
                mode_eff == MODE_SOLID  ? i_fg :
                mode_eff == MODE_BARS   ? bar_rgb :
                mode_eff == MODE_CHECK  ? (chk_on ? i_fg : '0) :
                in_box                  ? i_fg : '0;
   end

   // one step of box motion; reaching a bound clamps there and flips that axis
   always_comb begin
      bx_d     = dx_neg_q ? bx_q - 10'd1 : bx_q + 10'd1;
      dx_neg_d = dx_neg_q;
      by_d     = dy_neg_q ? by_q - 10'd1 : by_q + 10'd1;
      dy_neg_d = dy_neg_q;
      if (!dx_neg_q && bx_q >= BX_MAX - 10'd1) begin
         bx_d     = BX_MAX;
         dx_neg_d = 1'b1;
      end
      if (dx_neg_q && bx_q <= 10'd1) begin
         bx_d     = '0;
         dx_neg_d = 1'b0;
      end
      if (!dy_neg_q && by_q >= BY_MAX - 10'd1) begin
         by_d     = BY_MAX;
         dy_neg_d = 1'b1;
      end
      if (dy_neg_q && by_q <= 10'd1) begin
         by_d     = '0;
         dy_neg_d = 1'b0;
      end
   end

   // output registers and per-frame state; box moves as the scan wraps so the whole next frame sees it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_q     <= ~SYNC_POL;
         vs_q     <= ~SYNC_POL;
         de_q     <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         rgb_q    <= '0;
         frame_q  <= '0;
         mode_q   <= MODE_SOLID;
         bx_q     <= '0;
         by_q     <= '0;
         dx_neg_q <= 1'b0;
         dy_neg_q <= 1'b0;
      end else if (pix_en) begin
         hs_q   <= hs_raw ? SYNC_POL : ~SYNC_POL;
         vs_q   <= vs_raw ? SYNC_POL : ~SYNC_POL;
         de_q   <= de_raw;
         x_q    <= hc;
         y_q    <= vc;
         rgb_q  <= rgb_d;
         mode_q <= mode_eff;
         if (frame_end) begin
            frame_q  <= frame_q + 16'd1;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
         end
      end
   end

   assign {o_red, o_green, o_blue} = rgb_q;
   assign o_hs      = hs_q;
   assign o_vs      = vs_q;
   assign o_disp_en = de_q;
   assign o_x       = x_q;
   assign o_y       = y_q;
   assign o_frame   = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed checks of timing, patterns, box motion and reset on a shrunken raster
module tb_vga_pattern_gen;

   // 24x16 raster, 2 clocks per pixel: line = 48 clocks, frame = 768 clocks
   localparam int HA = 16;
   localparam int VA = 12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic [11:0] fg;
   logic [3:0]  red, green, blue;
   logic        hs, vs, de;
   logic [9:0]  x, y;
   logic [15:0] frame;
   logic [11:0] rgb;

   int vectors     = 0;
   int miscompares = 0;
   bit dead        = 1'b0;
   int f, lo, per, n, de_clks, de_lines, bad;
   logic prev_de;

   always #5 clk = ~clk;

   assign rgb = {red, green, blue};

   vga_pattern_gen #(
      .CLK_DIV (2),
      .COLOR_W (4),
      .H_ACTIVE(HA),
      .H_FP    (2),
      .H_SYNC  (3),
      .H_BP    (3),
      .V_ACTIVE(VA),
      .V_FP    (1),
      .V_SYNC  (2),
      .V_BP    (1),
      .SYNC_POL(1'b0),
      .CHK_LOG2(2),
      .BOX_SIZE(4)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_mode   (mode),
      .i_fg     (fg),
      .o_red    (red),
      .o_green  (green),
      .o_blue   (blue),
      .o_hs     (hs),
      .o_vs     (vs),
      .o_disp_en(de),
      .o_x      (x),
      .o_y      (y),
      .o_frame  (frame)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to the sample where pixel (px,py) of frame fr is on the outputs
   task automatic goto(input int fr, input int px, input int py);
      int   cnt;
      logic de_e;
      cnt  = 0;
      de_e = px < HA && py < VA;
      if (dead) return;
      while (!(frame == 16'(fr) && x == 10'(px) && y == 10'(py) && de == de_e) && cnt < 8000) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 8000) dead = 1'b1;
      chk($sformatf("reach f%0d (%0d,%0d)", fr, px, py), 32'(cnt < 8000), 32'd1);
   endtask

   function automatic logic sig(input bit v);
      return v ? vs : hs;
   endfunction

   // clocks a sync stays low, and clocks from one falling edge to the next
   task automatic meas(input bit v, output int low, output int period);
      int cnt;
      cnt = 0;
      while (sig(v) !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
      cnt = 0;
      while (sig(v) !== 1'b0 && cnt < 2000) begin @(negedge clk); cnt++; end
      low = 0;
      while (sig(v) === 1'b0 && low < 2000) begin @(negedge clk); low++; end
      period = low;
      while (sig(v) === 1'b1 && period < 4000) begin @(negedge clk); period++; end
   endtask

   initial begin
      rst_n = 1'b0;
      mode  = 2'd0;
      fg    = 12'hF00;
      repeat (3) @(negedge clk);
      chk("rst hs", 32'(hs), 32'd1);
      chk("rst vs", 32'(vs), 32'd1);
      chk("rst de", 32'(de), 32'd0);
      chk("rst x", 32'(x), 32'd0);
      chk("rst y", 32'(y), 32'd0);
      chk("rst frame", 32'(frame), 32'd0);
      chk("rst rgb", 32'(rgb), 32'h000);
      rst_n = 1'b1;

      meas(1'b0, lo, per);
      chk("hs low clks", 32'(lo), 32'd6);
      chk("h period clks", 32'(per), 32'd48);
      meas(1'b1, lo, per);
      chk("vs low clks", 32'(lo), 32'd96);
      chk("v period clks", 32'(per), 32'd768);

      f = int'(frame) + 1;
      goto(f, 0, 0);
      de_clks  = 0;
      de_lines = 0;
      bad      = 0;
      prev_de  = 1'b0;
      for (int i = 0; i < 768; i++) begin
         if (i > 0) @(negedge clk);
         if (de) de_clks++;
         if (de && !prev_de) de_lines++;
         if (de ? rgb !== 12'hF00 : rgb !== 12'h000) bad++;
         prev_de = de;
      end
      chk("solid de clks", 32'(de_clks), 32'd384);
      chk("solid de lines", 32'(de_lines), 32'd12);
      chk("solid bad pixels", 32'(bad), 32'd0);

      mode = 2'd1;
      f = int'(frame) + 1;
      goto(f, 1, 3);  chk("bar x1 white", 32'(rgb), 32'hFFF);
      goto(f, 2, 3);  chk("bar x2 yellow", 32'(rgb), 32'hFF0);
      goto(f, 4, 3);  chk("bar x4 cyan", 32'(rgb), 32'h0FF);
      goto(f, 7, 3);  chk("bar x7 green", 32'(rgb), 32'h0F0);
      goto(f, 8, 3);  chk("bar x8 magenta", 32'(rgb), 32'hF0F);
      goto(f, 10, 3); chk("bar x10 red", 32'(rgb), 32'hF00);
      goto(f, 13, 3); chk("bar x13 blue", 32'(rgb), 32'h00F);
      goto(f, 14, 3); chk("bar x14 black", 32'(rgb), 32'h000);
      goto(f, 17, 3); chk("bar fp rgb", 32'(rgb), 32'h000);
      chk("bar fp hs", 32'(hs), 32'd1);
      goto(f, 19, 3); chk("bar sync rgb", 32'(rgb), 32'h000);
      chk("bar sync hs", 32'(hs), 32'd0);

      mode = 2'd2;
      fg   = 12'h0F0;
      f = int'(frame) + 1;
      goto(f, 0, 0); chk("chk (0,0)", 32'(rgb), 32'h000);
      goto(f, 4, 0); chk("chk (4,0)", 32'(rgb), 32'h0F0);
      goto(f, 0, 4); chk("chk (0,4)", 32'(rgb), 32'h0F0);
      goto(f, 4, 4); chk("chk (4,4)", 32'(rgb), 32'h000);

      mode = 2'd0;
      f = int'(frame) + 1;
      goto(f, 0, 0); chk("sw solid (0,0)", 32'(rgb), 32'h0F0);
      goto(f, 0, 6);
      mode = 2'd2;
      goto(f, 0, 8);     chk("sw held (0,8)", 32'(rgb), 32'h0F0);
      goto(f + 1, 0, 0); chk("sw next (0,0)", 32'(rgb), 32'h000);
      goto(f + 1, 4, 0); chk("sw next (4,0)", 32'(rgb), 32'h0F0);

      goto(f + 1, 5, 3); chk("pre rst rgb", 32'(rgb), 32'h0F0);
      #2 rst_n = 1'b0;
      #1;
      chk("async x", 32'(x), 32'd0);
      chk("async y", 32'(y), 32'd0);
      chk("async frame", 32'(frame), 32'd0);
      chk("async rgb", 32'(rgb), 32'h000);
      chk("async hs", 32'(hs), 32'd1);
      chk("async de", 32'(de), 32'd0);
      mode = 2'd3;
      fg   = 12'hF00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!de && n < 10) begin @(negedge clk); n++; end
      chk("first pix clks", 32'(n), 32'd2);
      chk("first pix x", 32'(x), 32'd0);
      chk("first pix y", 32'(y), 32'd0);

      goto(0, 0, 0);   chk("box f0 (0,0)", 32'(rgb), 32'hF00);
      goto(0, 3, 3);   chk("box f0 (3,3)", 32'(rgb), 32'hF00);
      goto(0, 4, 3);   chk("box f0 (4,3)", 32'(rgb), 32'h000);
      goto(0, 0, 4);   chk("box f0 (0,4)", 32'(rgb), 32'h000);
      goto(5, 5, 5);   chk("box f5 (5,5)", 32'(rgb), 32'hF00);
      goto(5, 9, 5);   chk("box f5 (9,5)", 32'(rgb), 32'h000);
      goto(5, 8, 8);   chk("box f5 (8,8)", 32'(rgb), 32'hF00);
      goto(5, 5, 9);   chk("box f5 (5,9)", 32'(rgb), 32'h000);
      goto(8, 8, 7);   chk("box f8 (8,7)", 32'(rgb), 32'h000);
      goto(8, 8, 8);   chk("box f8 (8,8)", 32'(rgb), 32'hF00);
      goto(9, 9, 6);   chk("box f9 (9,6)", 32'(rgb), 32'h000);
      goto(9, 9, 7);   chk("box f9 (9,7)", 32'(rgb), 32'hF00);
      goto(12, 11, 4); chk("box f12 (11,4)", 32'(rgb), 32'h000);
      goto(12, 12, 4); chk("box f12 (12,4)", 32'(rgb), 32'hF00);
      goto(12, 15, 7); chk("box f12 (15,7)", 32'(rgb), 32'hF00);
      goto(13, 11, 3); chk("box f13 (11,3)", 32'(rgb), 32'hF00);
      goto(13, 14, 3); chk("box f13 (14,3)", 32'(rgb), 32'hF00);
      goto(13, 15, 3); chk("box f13 (15,3)", 32'(rgb), 32'h000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed solid-colour VGA top. Contains its own sync/timing generator and a pixel-clock-enable divider.
- Produces one of four selectable test patterns: solid colour, 8 colour bars, checkerboard, bouncing box.
- Sits directly between the board clock and the vgaRed/vgaGreen/vgaBlue/Hsync/Vsync pins. It is the demo's reusable display engine.

Parameters:
- CLK_DIV, 4, system clocks per pixel; pixel enable is generated internally (100 MHz -> 25 MHz).
- COLOR_W, 4, bits per colour channel.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, asserted sync level (0 = active-low).
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels.
- BOX_SIZE, 32, side length of the bouncing box in pixels.

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box
- i_fg  in  3*COLOR_W  foreground colour {R,G,B}
- o_red  out  COLOR_W  red channel
- o_green  out  COLOR_W  green channel
- o_blue  out  COLOR_W  blue channel
- o_hs  out  1  horizontal sync
- o_vs  out  1  vertical sync
- o_disp_en  out  1  high during visible pixels
- o_x  out  10  column of the pixel currently on the outputs
- o_y  out  10  row of the pixel currently on the outputs
- o_frame  out  16  frame counter, wraps at 2^16

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - On reset all counters are 0 and o_red/o_green/o_blue = 0.
  - o_hs and o_vs are driven to the deasserted level (~SYNC_POL); o_disp_en = 0; o_x = o_y = 0; o_frame = 0.
  - Box position resets to (0,0) with velocity (+1,+1). The latched mode resets to 0.
  - Reset mid-frame restarts the frame from (0,0). The first pix_en after reset release occurs CLK_DIV clocks later.
- Pixel enable (pix_en): divider counts 0..CLK_DIV-1; pix_en pulses for one clock when the count is CLK_DIV-1. All other state advances only on pix_en.
- Timing counters:
  - hc runs 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters); vc runs 0..V_TOTAL-1.
  - vc increments when hc wraps. o_frame increments when both wrap together.
- Sync and display enable:
  - Sync asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); likewise for vc.
  - disp_en = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Latency: all outputs are registered. They reflect counter values (hc,vc) one pix_en after those counters held them. Sync, disp_en, coordinates and colour stay mutually aligned.
- Blanking: colour outputs are forced to 0 whenever disp_en = 0.
- Frame-start events (hc=0 and vc=0 on a pix_en):
  - i_mode is sampled. A mode change mid-frame takes effect only at the next frame start.
  - The box position is updated.
- Patterns:
  - Mode 0 (solid): i_fg.
  - Mode 1 (bars): bar index k such that x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8). Boundaries are elaboration-time constants; no runtime divide. Colours k=0..7: white, yellow, cyan, green, magenta, red, blue, black. "On" channel = all ones.
  - Mode 2 (checker): i_fg when ((x>>CHK_LOG2) ^ (y>>CHK_LOG2)) bit0 = 1, else 0.
  - Mode 3 (box): i_fg when bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE, else 0.
- Box motion, applied at each frame start:
  - New position = position + velocity.
  - When bx+dx would leave [0, H_ACTIVE-BOX_SIZE], dx is negated and bx is clamped to the bound. Same rule for by against V_ACTIVE.
  - Box motion continues in every mode. Corner hit reverses both axes in the same frame.
- Widths: the 10-bit counters must hold H_TOTAL-1. Elaboration error if H_TOTAL > 1024 or V_TOTAL > 1024.

Decomposition:
- Package vga_pkg:
  - mode encodings MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_BOX.
  - the 8-entry bar colour table.
  - 640x480@60 timing constants, used as parameter defaults.
- One sub-module, vga_timing_gen:
  - contains the divider, hc/vc counters and raw sync/disp_en.
  - outputs pix_en, hc, vc and frame_start.
- Pattern logic, box motion and output registers stay in vga_pattern_gen.

Test Plan:
- Timing, default params, mode 0, i_fg=12'hF00, run 2 frames:
  - H period = 3200 clocks, o_hs low for 384 clocks.
  - V period = 1,680,000 clocks, o_vs low for 2 lines.
  - o_disp_en high for 640 pixels per line on 480 lines.
  - Visible pixels = F,0,0; blanked pixels = 0.
- Bars, mode 1:
  - pixel x=79 is white; x=80 is yellow; x=560 is black.
  - all channels are 0 in blanking.
- Checker, mode 2, i_fg=12'h0F0:
  - (0,0) is 0; (32,0) is green; (32,32) is 0.
- Box, mode 3:
  - frame 0 box at (0,0), frame 5 box at (5,5).
  - on reaching bx=608 (H_ACTIVE-BOX_SIZE), next frame bx=607.
  - by reverses at 448.
- Mode switch mid-frame (0->2 at line 100): output stays solid until o_frame increments, then becomes checkerboard.
- Reset:
  - assert i_rst_n low mid-line for 3 clocks: outputs go to reset values immediately, without waiting for a clock edge.
  - after release, hc restarts at 0; o_frame = 0; box returns to (0,0).
